uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
Parametrised UART transmit framer for the AHB UART, succeeding the combinational parity generator. It accepts a parallel character over a valid/ready handshake, computes a parity bit according to a runtime-selectable mode (with fault injection), and serialises start, data, parity and stop bits onto tx_out. Each bit lasts one baud_tick period, supplied by the baud generator. It sits between the TX FIFO and the UART pin.

Parameters:
DATA_WIDTH, 8, character width in bits; legal range 5..9.
STATE_W, 3, state register width; fixed and not to be overridden.

Ports:
HCLK  in  1  system clock; all logic is rising-edge.
HRESETn  in  1  asynchronous active-low reset.
baud_tick  in  1  single-cycle pulse, one per bit period.
cfg_parity_mode  in  3  000 none, 001 even, 010 odd, 011 mark (1), 100 space (0); codes 101..111 are treated as none.
cfg_two_stop  in  1  1 gives two stop bits, 0 gives one.
parity_fault_injection  in  1  1 inverts the transmitted parity bit.
tx_data  in  DATA_WIDTH  character to send.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  framer can accept a character.
tx_out  out  1  serial line; idles high.
busy  out  1  a frame is in progress (any state other than IDLE).
frame_done  out  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, tx_out=1, tx_ready=1, busy=0, frame_done=0, bit counter=0. Shift and config registers go to 0.
- States are IDLE, SYNC, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1, tx_out=1. baud_tick is ignored.
  - On tx_valid&tx_ready, in the same edge, latch the following, then go to SYNC:
    - tx_data;
    - cfg_parity_mode and cfg_two_stop;
    - the computed parity bit, with parity_fault_injection sampled at this edge.
  - Later changes on config inputs do not affect the frame in flight.
- tx_ready=0 in every state except IDLE. tx_valid may drop without a handshake and there is no penalty.
- SYNC: tx_out=1. Wait for baud_tick, then go to START, so the start bit is a full bit period.
- Bit timing: every bit state drives its value from the cycle after the entering tick until the next baud_tick inclusive. On that tick, advance.
- START: tx_out=0. On tick, go to DATA with counter=0.
- DATA:
  - tx_out = data[counter], LSB first.
  - On tick: if counter==DATA_WIDTH-1, go to PARITY (or STOP if mode is none); else counter+1.
- PARITY: tx_out = latched parity bit. On tick, go to STOP.
- STOP: tx_out=1. On tick, go to IDLE if one stop bit (or the second one is done), else stay for one more tick. frame_done=1 for the single cycle in which STOP exits on its final tick.
- Parity rule:
  - even = ^data, so the total count of ones is even; odd = ~^data; mark=1; space=0.
  - When parity_fault_injection=1, the latched parity bit is inverted.
  - Fault injection is ignored when mode is none.
- Frame length in bit periods is 1 + DATA_WIDTH + P + S, where P is 0 or 1 and S is 1 or 2.
- Back-to-back frames: the next accept happens at the earliest in the cycle after frame_done. That frame passes through SYNC, so the line stays idle-high until the next tick.
- baud_tick asserted in the same cycle as an accept is not counted; SYNC waits for a later tick.
- Reset mid-frame: tx_out returns to 1 asynchronously, the frame is dropped, and no frame_done is produced.
- Outputs are registered. tx_out comes from a flop, with no combinational path from any input.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE;
  - the state encoding typedef (IDLE..STOP);
  - the legal DATA_WIDTH bounds.
- One sub-module, uart_parity_calc: combinational, parametrised on DATA_WIDTH. Its inputs are data, mode and fault; its output is the parity bit. It is reused later by the RX checker.

Test Plan:
- Reset: hold HRESETn=0 mid-stimulus -> tx_out=1, tx_ready=1, busy=0, frame_done=0 immediately.
- DATA_WIDTH=8, tx_data=0x55, even parity, one stop -> after the sync tick the line reads 0,1,0,1,0,1,0,1,0, then parity 0, then stop 1. frame_done pulses on the 11th tick after SYNC exits.
- tx_data=0x55, odd parity, fault injection=1 -> parity bit is 0 (nominal 1 inverted); all other bits are unchanged.
- tx_data=0xA3, mode none, two stop -> line reads 0,1,1,0,0,0,1,0,1,1,1, which is 11 bit periods. There is no parity slot, and fault injection has no effect.
- Reset asserted in DATA at counter=3 -> tx_out=1 the same cycle and no frame_done. A following 0x0F frame transmits correctly.
- tx_valid held high with 0x00 then 0xFF, mark mode -> both parity bits are 1. The second accept is in the cycle after the first frame_done, and its start bit begins only after the next tick.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART framing constants, state encoding and parity helpers
package uart_pkg;

  localparam int TX_STATE_W = 3;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

  localparam logic [2:0] PAR_NONE  = 3'b000;
  localparam logic [2:0] PAR_EVEN  = 3'b001;
  localparam logic [2:0] PAR_ODD   = 3'b010;
  localparam logic [2:0] PAR_MARK  = 3'b011;
  localparam logic [2:0] PAR_SPACE = 3'b100;

  typedef enum logic [TX_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_t;

  // Codes 101..111 behave like PAR_NONE: no parity slot on the line.
  function automatic logic parity_enabled(input logic [2:0] mode);
    logic en;
    case (mode)
      PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE: en = 1'b1;
      default:                                en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - combinational parity bit generator shared by TX framer and RX checker
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [2:0]            mode,
  input  logic                  fault,
  output logic                  parity
);

  logic nominal;

  // Pick the nominal parity for the mode, then flip it only when a parity slot exists.
  always_comb begin
    nominal = 1'b0;
    case (mode)
      PAR_EVEN:  nominal = ^data;
      PAR_ODD:   nominal = ~^data;
      PAR_MARK:  nominal = 1'b1;
      PAR_SPACE: nominal = 1'b0;
      default:   nominal = 1'b0;
    endcase
    parity = nominal ^ (fault & parity_enabled(mode));
  end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: handshake in, start/data/parity/stop bits out
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STATE_W    = 3
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  baud_tick,
  input  logic [2:0]            cfg_parity_mode,
  input  logic                  cfg_two_stop,
  input  logic                  parity_fault_injection,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  generate
    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
      $error("uart_tx_framer: DATA_WIDTH out of range");
    end
    if (STATE_W != TX_STATE_W) begin : g_bad_state_w
      $error("uart_tx_framer: STATE_W must match the package state encoding");
    end
  endgenerate

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] data_q;
  logic [2:0]            mode_q;
  logic                  two_stop_q;
  logic                  parity_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  second_stop;
  logic                  parity_bit;

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data   (tx_data),
    .mode   (cfg_parity_mode),
    .fault  (parity_fault_injection),
    .parity (parity_bit)
  );

  // Frame sequencer: each bit state holds its line value until the next tick, then loads the next one.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      tx_out      <= 1'b1;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      bit_cnt     <= '0;
      data_q      <= '0;
      mode_q      <= PAR_NONE;
      two_stop_q  <= 1'b0;
      parity_q    <= 1'b0;
      second_stop <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A tick coinciding with the accept is deliberately ignored; SYNC waits for a fresh one.
          if (tx_valid && tx_ready) begin
            data_q      <= tx_data;
            mode_q      <= cfg_parity_mode;
            two_stop_q  <= cfg_two_stop;
            parity_q    <= parity_bit;
            bit_cnt     <= '0;
            second_stop <= 1'b0;
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (baud_tick) begin
            tx_out <= 1'b0;
            state  <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            bit_cnt <= '0;
            tx_out  <= data_q[0];
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_BIT) begin
              if (parity_enabled(mode_q)) begin
                tx_out <= parity_q;
                state  <= ST_PARITY;
              end else begin
                tx_out <= 1'b1;
                state  <= ST_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              data_q  <= data_q >> 1;
              tx_out  <= data_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            tx_out <= 1'b1;
            state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (two_stop_q && !second_stop) begin
              second_stop <= 1'b1;
            end else begin
              tx_ready   <= 1'b1;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_IDLE;
            end
          end
        end
        default: begin
          tx_out   <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - scoreboard bench for uart_tx_framer
module tb_uart_tx_framer;
  import uart_pkg::*;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       baud_tick = 1'b0;
  logic [2:0] cfg_parity_mode = PAR_NONE;
  logic       cfg_two_stop = 1'b0;
  logic       parity_fault_injection = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  int total = 0;
  int bad = 0;
  int bits_seen = 0;
  int tick_cnt = 0;
  bit exp_bits[$];
  int exp_len[$];

  uart_tx_framer #(
    .DATA_WIDTH (8)
  ) dut (
    .HCLK                   (HCLK),
    .HRESETn                (HRESETn),
    .baud_tick              (baud_tick),
    .cfg_parity_mode        (cfg_parity_mode),
    .cfg_two_stop           (cfg_two_stop),
    .parity_fault_injection (parity_fault_injection),
    .tx_data                (tx_data),
    .tx_valid               (tx_valid),
    .tx_ready               (tx_ready),
    .tx_out                 (tx_out),
    .busy                   (busy),
    .frame_done             (frame_done)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One-cycle baud tick every 5 clocks, changed just after the rising edge.
  initial begin
    forever begin
      @(posedge HCLK);
      #1;
      tick_cnt  = (tick_cnt == 4) ? 0 : tick_cnt + 1;
      baud_tick = (tick_cnt == 4);
    end
  end

  // Monitor: one line sample per tick while busy (sync slot included), frame length checked on frame_done.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (baud_tick && busy) begin
        if (exp_bits.size() == 0) begin
          check_eq("unexpected_line_bit", 1, 0);
        end else begin
          check_eq("line_bit", int'(tx_out), int'(exp_bits.pop_front()));
          bits_seen++;
        end
      end
      if (frame_done) begin
        if (exp_len.size() == 0) begin
          check_eq("spurious_frame_done", 1, 0);
        end else begin
          check_eq("frame_len", bits_seen, exp_len.pop_front());
          bits_seen = 0;
        end
      end
    end
  end

  // Expected line, written left to right in transmit order: sync, start, data LSB first, parity, stops.
  task automatic push_frame(input logic [15:0] line, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bits.push_back(line[i]);
    exp_len.push_back(n);
  endtask

  task automatic wait_ready();
    int cyc = 0;
    @(posedge HCLK); #2;
    while (!tx_ready && cyc < 2000) begin
      @(posedge HCLK); #2;
      cyc++;
    end
    if (!tx_ready) check_eq("ready_timeout", 0, 1);
  endtask

  task automatic wait_frames_done();
    int cyc = 0;
    while (exp_len.size() != 0 && cyc < 3000) begin
      @(posedge HCLK); #2;
      cyc++;
    end
    check_eq("frames_drained", exp_len.size(), 0);
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] mode, input logic ts, input logic fault,
                      input logic [15:0] line, input int n, input bit align_tick);
    int cyc = 0;
    wait_ready();
    if (align_tick) begin
      while (!baud_tick && cyc < 20) begin
        @(posedge HCLK); #2;
        cyc++;
      end
      check_eq("align_tick", int'(baud_tick), 1);
    end
    tx_data                = d;
    cfg_parity_mode        = mode;
    cfg_two_stop           = ts;
    parity_fault_injection = fault;
    tx_valid               = 1'b1;
    push_frame(line, n);
    @(posedge HCLK); #2;
    tx_valid = 1'b0;
    check_eq("accept_ready_low", int'(tx_ready), 0);
    check_eq("accept_busy", int'(busy), 1);
    // Disturb every config input; the frame in flight must keep its latched settings.
    tx_data                = ~d;
    cfg_parity_mode        = ~mode;
    cfg_two_stop           = ~ts;
    parity_fault_injection = ~fault;
  endtask

  initial begin
    int cyc;

    repeat (3) @(posedge HCLK);
    #2;
    check_eq("reset_tx_out", int'(tx_out), 1);
    check_eq("reset_tx_ready", int'(tx_ready), 1);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_frame_done", int'(frame_done), 0);
    HRESETn = 1'b1;

    // 0x55 even, one stop: parity 0
    send(8'h55, PAR_EVEN, 1'b0, 1'b0, 16'b1_0_10101010_0_1, 12, 1'b0);
    wait_frames_done();
    // 0x55 odd with fault: nominal 1 inverted to 0
    send(8'h55, PAR_ODD, 1'b0, 1'b1, 16'b1_0_10101010_0_1, 12, 1'b0);
    wait_frames_done();
    // 0xA3 none, two stops, fault ignored
    send(8'hA3, PAR_NONE, 1'b1, 1'b1, 16'b1_0_11000101_1_1, 12, 1'b0);
    wait_frames_done();

    // 0x30 frame dropped by reset while sending data bit 3 (a 0)
    send(8'h30, PAR_EVEN, 1'b0, 1'b0, 16'b1_0_00001100_0_1, 12, 1'b0);
    cyc = 0;
    while (bits_seen < 5 && cyc < 200) begin
      @(posedge HCLK); #2;
      cyc++;
    end
    check_eq("mid_frame_bits", bits_seen, 5);
    check_eq("mid_frame_line_low", int'(tx_out), 0);
    HRESETn = 1'b0;
    #1;
    check_eq("async_reset_tx_out", int'(tx_out), 1);
    check_eq("async_reset_ready", int'(tx_ready), 1);
    check_eq("async_reset_busy", int'(busy), 0);
    check_eq("async_reset_done", int'(frame_done), 0);
    exp_bits.delete();
    exp_len.delete();
    bits_seen = 0;
    repeat (3) @(posedge HCLK);
    #2;
    HRESETn = 1'b1;

    // 0x0F even after reset: parity 0
    send(8'h0F, PAR_EVEN, 1'b0, 1'b0, 16'b1_0_11110000_0_1, 12, 1'b0);
    wait_frames_done();

    // Back-to-back with tx_valid held: 0x00 then 0xFF, mark parity
    wait_ready();
    tx_data                = 8'h00;
    cfg_parity_mode        = PAR_MARK;
    cfg_two_stop           = 1'b0;
    parity_fault_injection = 1'b0;
    tx_valid               = 1'b1;
    push_frame(16'b1_0_00000000_1_1, 12);
    cyc = 0;
    do begin
      @(posedge HCLK); #2;
      cyc++;
    end while (tx_ready && cyc < 20);
    check_eq("b2b_first_accept", int'(tx_ready), 0);
    tx_data = 8'hFF;
    push_frame(16'b1_0_11111111_1_1, 12);
    cyc = 0;
    while (!frame_done && cyc < 2000) begin
      @(posedge HCLK); #2;
      cyc++;
    end
    check_eq("b2b_first_done", int'(frame_done), 1);
    check_eq("b2b_ready_at_done", int'(tx_ready), 1);
    @(posedge HCLK); #2;
    check_eq("b2b_second_accept", int'(tx_ready), 0);
    check_eq("b2b_second_busy", int'(busy), 1);
    tx_valid = 1'b0;
    wait_frames_done();

    // 0x81 space, two stops, accept in the same cycle as a tick
    send(8'h81, PAR_SPACE, 1'b1, 1'b0, 16'b1_0_10000001_0_1_1, 13, 1'b1);
    wait_frames_done();

    check_eq("queue_empty", exp_bits.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
